// File: rtl/gbuff_stream_reader_pkg.sv
// Shared global-buffer definitions: word geometry and stream-reader FSM encodings.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gbuff_stream_reader_pkg;

    localparam int WORD_SIZE      = 16;
    localparam int WORD_ADDR_BITS = 8;
    localparam int WORD_CNT       = 1 << WORD_ADDR_BITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/gbuff_rd_fifo.sv
// Two-entry FIFO holding global-buffer read data ahead of the output stream.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: none internally; the caller's credit rule guarantees no push when full.
//
// Ports: clk/reset (sync, active-high); push/push_data write side;
// pop read side (caller only pops when valid); valid, head_data, count status.
module gbuff_rd_fifo
    import gbuff_stream_reader_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [WORD_SIZE-1:0] push_data,
    input  logic                 pop,
    output logic                 valid,
    output logic [WORD_SIZE-1:0] head_data,
    output logic [1:0]           count
);

    logic [WORD_SIZE-1:0] mem_q [2];
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [1:0]           cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Storage is cleared so the head reads as zero after reset.
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 2'd1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 2'd1;
            end
        end
    end

    assign valid     = (cnt_q != 2'd0);
    assign head_data = mem_q[rd_ptr_q];
    assign count     = cnt_q;

endmodule

// File: rtl/gbuff_stream_reader.sv
// Streams a burst of global-buffer words (base_addr, length) out on a valid/ready port.
// Latency: first word valid 2 cycles after the start edge; one word per cycle when out_ready is high.
// Backpressure: reads are credit-limited to 2 (FIFO + in flight); out_valid/out_data hold while stalled.
//
// Ports: clk/reset (sync, active-high); start/base_addr/length burst request;
// busy/done status; sram_wen/sram_addr/sram_do global-buffer read port (1-cycle read);
// out_valid/out_data/out_ready output stream.
module gbuff_stream_reader
    import gbuff_stream_reader_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [WORD_ADDR_BITS-1:0] base_addr,
    input  logic [WORD_ADDR_BITS:0]   length,
    output logic                      busy,
    output logic                      done,
    output logic                      sram_wen,
    output logic [WORD_ADDR_BITS-1:0] sram_addr,
    input  logic [WORD_SIZE-1:0]      sram_do,
    output logic                      out_valid,
    output logic [WORD_SIZE-1:0]      out_data,
    input  logic                      out_ready
);

    state_t                    state_q;
    state_t                    state_d;
    logic [WORD_ADDR_BITS-1:0] addr_q;
    logic [WORD_ADDR_BITS:0]   rd_left_q;
    logic [WORD_ADDR_BITS:0]   out_left_q;
    logic                      inflight_q;
    logic                      done_q;

    logic                      fifo_valid;
    logic [1:0]                fifo_cnt;
    logic                      pop;
    logic                      issue;
    logic [2:0]                pending;
    logic                      credit_ok;

    assign pop = fifo_valid & out_ready;

    // Occupancy is taken after this cycle's pop so a word leaving the FIFO frees
    // its slot immediately; without that the stream could not sustain one word per cycle.
    assign pending   = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    assign credit_ok = (pending < 3'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (length != '0)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (rd_left_q == (WORD_ADDR_BITS + 1)'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && (out_left_q == (WORD_ADDR_BITS + 1)'(1))) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            rd_left_q  <= '0;
            out_left_q <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            inflight_q <= issue;
            done_q     <= 1'b0;
            if ((state_q == ST_IDLE) && start) begin
                // A zero-length burst only produces the done pulse; no address is latched.
                if (length == '0) begin
                    done_q <= 1'b1;
                end else begin
                    addr_q     <= base_addr;
                    rd_left_q  <= length;
                    out_left_q <= length;
                end
            end
            if (issue) begin
                addr_q    <= addr_q + WORD_ADDR_BITS'(1);
                rd_left_q <= rd_left_q - (WORD_ADDR_BITS + 1)'(1);
            end
            if (pop) begin
                out_left_q <= out_left_q - (WORD_ADDR_BITS + 1)'(1);
                if ((state_q == ST_DRAIN) && (out_left_q == (WORD_ADDR_BITS + 1)'(1))) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    // Read data returns one cycle after issue, so the in-flight flag is the push strobe.
    gbuff_rd_fifo u_rd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_data (sram_do),
        .pop       (pop),
        .valid     (fifo_valid),
        .head_data (out_data),
        .count     (fifo_cnt)
    );

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign sram_wen  = 1'b0;
    assign sram_addr = addr_q;
    assign out_valid = fifo_valid;

endmodule

// File: tb/tb_gbuff_stream_reader.sv
// Directed bench for gbuff_stream_reader with a 1-cycle global-buffer read model.
// Latency: n/a (testbench).
// Backpressure: out_ready driven either constantly high or toggling 1,0,1,0.
module tb_gbuff_stream_reader;
    import gbuff_stream_reader_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      start;
    logic [WORD_ADDR_BITS-1:0] base_addr;
    logic [WORD_ADDR_BITS:0]   length;
    logic                      busy;
    logic                      done;
    logic                      sram_wen;
    logic [WORD_ADDR_BITS-1:0] sram_addr;
    logic [WORD_SIZE-1:0]      sram_do = '0;
    logic                      out_valid;
    logic [WORD_SIZE-1:0]      out_data;
    logic                      out_ready;

    int n_checks = 0;
    int n_errors = 0;

    gbuff_stream_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .sram_wen  (sram_wen),
        .sram_addr (sram_addr),
        .sram_do   (sram_do),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Contents of the global buffer: each word encodes its own address.
    function automatic logic [WORD_SIZE-1:0] mem_word(input logic [WORD_ADDR_BITS-1:0] a);
        return WORD_SIZE'({~a, a});
    endfunction

    always @(posedge clk) sram_do <= mem_word(sram_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issues one burst starting at the current negedge and watches it to completion.
    // cyc counts clock edges after the start edge (cyc 0 = cycle right after start).
    task automatic run_burst(input string tag, input logic [7:0] base, input logic [8:0] len,
                             input bit toggle_rdy, input int abort_after, input int restart_cyc);
        int cyc, xfer, issued, first_x, last_x, done_cyc, max_out, stall_bad, busy_bad;
        logic [WORD_ADDR_BITS-1:0] prev_addr, addr_before;
        logic [WORD_SIZE-1:0] stall_data;
        logic stalled;
        logic [7:0] exp_addr;
        addr_before = sram_addr;
        start = 1'b1; base_addr = base; length = len;
        @(negedge clk);
        start = 1'b0;
        xfer = 0; issued = 0; first_x = -1; last_x = -1; done_cyc = -1;
        max_out = 0; stall_bad = 0; busy_bad = 0; stalled = 1'b0; stall_data = '0;
        prev_addr = sram_addr;
        for (cyc = 0; cyc < 300; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cyc == restart_cyc) begin
                start = 1'b1; base_addr = 8'h99; length = 9'd5;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (!busy) busy_bad++;
            if (cyc > 0 && sram_addr != prev_addr) issued++;
            prev_addr = sram_addr;
            if (issued - xfer > max_out) max_out = issued - xfer;
            if (stalled && (!out_valid || out_data != stall_data)) stall_bad++;
            out_ready = toggle_rdy ? (cyc % 2 == 0) : 1'b1;
            if (out_valid && out_ready) begin
                exp_addr = base + xfer[7:0];
                check_eq($sformatf("%s word%0d", tag, xfer), 32'(out_data), 32'(mem_word(exp_addr)));
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
                xfer++;
            end
            stalled = out_valid && !out_ready;
            stall_data = out_data;
            if (abort_after > 0 && xfer == abort_after) return;
        end
        out_ready = 1'b1;
        check_eq({tag, " done_seen"}, 32'(done_cyc >= 0), 32'd1);
        check_eq({tag, " busy_at_done"}, 32'(busy), 32'd0);
        check_eq({tag, " valid_at_done"}, 32'(out_valid), 32'd0);
        check_eq({tag, " words"}, 32'(xfer), 32'(len));
        check_eq({tag, " reads_issued"}, 32'(issued), 32'(len));
        check_eq({tag, " busy_gaps"}, 32'(busy_bad), 32'd0);
        if (len != 0)
            check_eq({tag, " done_after_last"}, 32'(done_cyc), 32'(last_x + 1));
        if (toggle_rdy) begin
            check_eq({tag, " stall_hold"}, 32'(stall_bad), 32'd0);
            check_eq({tag, " max_outstanding_le2"}, 32'(max_out <= 2), 32'd1);
        end else if (len != 0) begin
            check_eq({tag, " first_word_cyc"}, 32'(first_x), 32'd2);
            check_eq({tag, " back_to_back"}, 32'(last_x - first_x), 32'(len - 1));
        end
        @(negedge clk);
        check_eq({tag, " done_one_cycle"}, 32'(done), 32'd0);
        if (len == 0) begin
            check_eq({tag, " addr_unchanged"}, 32'(sram_addr), 32'(addr_before));
            check_eq({tag, " busy_after"}, 32'(busy), 32'd0);
            check_eq({tag, " valid_after"}, 32'(out_valid), 32'd0);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, " busy"}, 32'(busy), 32'd0);
        check_eq({tag, " done"}, 32'(done), 32'd0);
        check_eq({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, " out_data"}, 32'(out_data), 32'd0);
        check_eq({tag, " sram_addr"}, 32'(sram_addr), 32'd0);
        check_eq({tag, " sram_wen"}, 32'(sram_wen), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        run_burst("basic",   8'h10, 9'd4, 1'b0, 0, -1);
        run_burst("toggle",  8'h30, 9'd8, 1'b1, 0, -1);
        run_burst("wrap",    8'hFE, 9'd4, 1'b0, 0, -1);
        run_burst("zero",    8'h55, 9'd0, 1'b0, 0, -1);
        run_burst("restart", 8'h20, 9'd6, 1'b1, 0, 3);

        // Abort a 16-word burst after its third word, then restart right out of reset.
        run_burst("rst16", 8'h40, 9'd16, 1'b0, 3, -1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("midreset");
        reset = 1'b0;
        run_burst("after_rst", 8'h00, 9'd2, 1'b0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gbuff_stream_reader.md
GBUFF_STREAM_READER -- requirements
Module: gbuff_stream_reader

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  reset, synchronous, active-high.
REQ-003 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-004 base_addr  input  WORD_ADDR_BITS  first global-buffer word address, latched on accepted start.
REQ-005 length  input  WORD_ADDR_BITS+1  number of words to stream (0 to 2^WORD_ADDR_BITS), latched on accepted start.
REQ-006 busy  output  1  high from the cycle after an accepted start until done.
REQ-007 done  output  1  one-cycle pulse when the burst completes.
REQ-008 sram_wen  output  1  global-buffer write enable; tied 0 (read-only client).
REQ-009 sram_addr  output  WORD_ADDR_BITS  global-buffer read address.
REQ-010 sram_do  input  WORD_SIZE  global-buffer read data, valid exactly one cycle after sram_addr is presented with sram_wen=0.
REQ-011 out_valid  output  1  out_data holds a streamed word.
REQ-012 out_data  output  WORD_SIZE  streamed word, in ascending address order.
REQ-013 out_ready  input  1  downstream accepts; transfer occurs when out_valid and out_ready are both high at a clock edge.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-015 IDLE->RUN on start with length>0; on start with length=0, the block SHALL stay in IDLE, pulse done on the next cycle and issue no reads.
REQ-016 In RUN, one read SHALL be issued per cycle when the credit rule allows: (FIFO occupancy + reads in flight) < 2.
REQ-017 sram_addr SHALL start at base_addr and increment by 1 per issued read, wrapping modulo 2^WORD_ADDR_BITS.
REQ-018 Read data SHALL be captured into a 2-entry FIFO one cycle after issue; no word may be lost or duplicated under any out_ready pattern.
REQ-019 RUN->DRAIN when the length-th read is issued; DRAIN->IDLE when the last word transfers on the output.
REQ-020 done SHALL pulse in the cycle after the last output transfer, and busy SHALL fall in that same cycle.
REQ-021 With out_ready held high, sustained throughput SHALL be one word per cycle, and first-word latency SHALL be 2 cycles from start (start edge -> read issue -> FIFO -> out_valid).
REQ-022 out_valid SHALL NOT drop while high until a transfer occurs, and out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 A start asserted while busy SHALL be ignored, with no effect on the current burst.
REQ-024 out_valid SHALL be 0 in IDLE.

Reset
REQ-025 On reset: state=IDLE; busy=0, done=0, out_valid=0, out_data=0, sram_addr=0, sram_wen=0; FIFO emptied; the in-flight read is discarded.
REQ-026 Reset asserted mid-burst SHALL abort the burst without a done pulse, and the block SHALL accept a new start in the first cycle after reset deasserts.

Structure
REQ-027 WORD_SIZE, WORD_ADDR_BITS, WORD_CNT and the FSM state encodings SHALL live in the shared define file used by the global buffer.
REQ-028 The 2-entry FIFO SHALL be a sub-module named gbuff_rd_fifo with the same clk and reset.

Verification
REQ-029 base_addr=0x010, length=4, out_ready=1 -> words from addresses 0x010..0x013 on 4 consecutive cycles, first word 2 cycles after start, done one cycle after the last transfer.
REQ-030 length=8, out_ready toggling 1,0,1,0… -> all 8 words delivered in order, none duplicated, out_data stable during stalls, issued reads never exceed 2 outstanding.
REQ-031 base_addr=2^WORD_ADDR_BITS-2, length=4 -> addresses max-1, max, 0, 1 in order.
REQ-032 length=0 -> done pulses one cycle after start, no read issued, out_valid stays 0, busy stays 0.
REQ-033 reset asserted after the 3rd word of a 16-word burst -> all outputs 0 next cycle, no done pulse; a new start with base 0, length 2 then completes normally.
REQ-034 start pulsed again mid-burst with a different base_addr -> ignored; original sequence completes unchanged.
